locked_adder_response_checker: RTL and testbench
================================================

# locked_adder_response_checker

Streaming response checker for locked-adder key evaluation runs. It sits on the DUT output side of the simulation harness and receives operand pairs together with the locked adder's observed sum. It recomputes the golden sum and counts mismatching vectors and corrupted output bits over a programmed window. When the window closes it emits one report per applied key over a valid/ready handshake.

## Interface
- `WIDTH`, 16: operand width; observed and golden results are `WIDTH+1` bits.
- `CNT_W`, 16: width of the vector counters.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse; latches `num_vectors`, clears all counters, enters RUN.
- `num_vectors` in CNT_W: window length in vectors; sampled only on `start`.
- `in_valid` in 1: vector present.
- `in_ready` out 1: checker accepts a vector this cycle.
- `in_a`, `in_b` in WIDTH: operands applied to the DUT.
- `in_result` in WIDTH+1: observed DUT sum.
- `busy` out 1: high in RUN or DRAIN.
- `rpt_valid` out 1: report available.
- `rpt_ready` in 1: report consumer ready.
- `rpt_vectors` out CNT_W: vectors checked.
- `rpt_err_vectors` out CNT_W: vectors with any mismatching bit.
- `rpt_err_bits` out CNT_W+8: total mismatching bits (sum of Hamming distances).
- `rpt_first_idx` out CNT_W: index of the first failing vector.
- `rpt_first_a`, `rpt_first_b` out WIDTH: operands of the first failing vector.
- `rpt_first_result` out WIDTH+1: observed sum of the first failing vector.
- `rpt_first_hit` out 1: at least one failure was captured.

## Operation
- FSM states are IDLE, RUN, DRAIN and REPORT. Reset enters IDLE.
- On reset, every output and counter is 0 and the FSM is in IDLE.
- `in_ready` = (state==RUN) && (accepted < target) && !start.
- Accept: `in_valid && in_ready` at a rising edge.
- Golden sum: zero-extended `in_a + in_b`, WIDTH+1 bits, no truncation.
- Mismatch: `golden ^ in_result`. The error-bit increment is popcount(mismatch), range 0..WIDTH+1. `rpt_err_vectors` increments when the mismatch is nonzero.
- `rpt_err_bits` cannot overflow for WIDTH ≤ 255. The counter still saturates at its all-ones value.
- Transition RUN→DRAIN: on the edge that accepts vector number `target`.
- Transition DRAIN→REPORT: once the pipeline is empty (2 cycles).
- Transition REPORT→IDLE: on `rpt_valid && rpt_ready`.
- `start` is honoured in every state. It aborts in-flight vectors and any pending report, clears the counters, and enters RUN. When `start` and `in_valid` coincide, `start` wins and the vector is not accepted.
- `num_vectors`=0 on `start`: go RUN→DRAIN immediately, then report all-zero counts.
- Report fields are stable while `rpt_valid` is high. They remain readable after the handshake until the next `start` or `rst`.
- `rst` asserted mid-run: asynchronous return to IDLE with all state cleared. No report is produced.

## Timing
- Pipeline stage 1 registers the operands, result and golden sum on accept. Stage 2 registers the popcount and updates the accumulators.
- Last vector accepted at edge N: counters are final at edge N+2, and `rpt_valid` rises at edge N+2.
- Throughput: one vector per cycle. There is no bubble between back-to-back vectors.
- `rpt_valid` falls on the edge after the handshake. `in_ready` stays low from acceptance of the final vector until the next `start`.
- `start` at edge S: `in_ready` can first be high in the cycle after S.

## Configuration
- Macro: `CHECKER_FIRST_FAIL_EN`.
- Defined: the first failing vector's index, operands and observed result are captured in stage 2. The capture is held until `start` or `rst`, and `rpt_first_hit` is set with it.
- Not defined: no capture registers are built. All `rpt_first_*` ports are tied to 0.

## Test plan
- Match case: after reset, `start` with `num_vectors`=3. Send (16'h0001, 16'h0001, 17'h00002), (16'hFFFF, 16'h0001, 17'h10000) and (16'h1234, 16'h4321, 17'h05555). Required: `rpt_vectors`=3, `rpt_err_vectors`=0, `rpt_err_bits`=0, `rpt_first_hit`=0, and `rpt_valid` two cycles after the last accept.
- Corruption: `num_vectors`=2 with (16'h0001, 16'h0001, 17'h00003) and (16'h00FF, 16'h0001, 17'h000FF). Required: `rpt_err_vectors`=2, `rpt_err_bits`=1+9=10. With the macro defined: `rpt_first_idx`=0 and `rpt_first_result`=17'h00003.
- Backpressure: hold `rpt_ready`=0 for 5 cycles after `rpt_valid`. Required: the report stays stable, `in_ready`=0 and `busy`=0; `rpt_valid` drops one cycle after `rpt_ready`=1.
- Restart mid-run: `start` with `num_vectors`=4, 2 vectors sent, then `start` with `num_vectors`=1 and `in_valid` high in the same cycle. Required: that vector is not accepted, and the final report has `rpt_vectors`=1.
- `num_vectors`=0: required report is all zeros, `rpt_valid` within 3 cycles of `start`.
- Async reset: assert `rst` mid-run with 1 vector in the pipeline. Required: `in_ready`, `busy` and `rpt_valid` fall without waiting for a clock edge, all counters read 0, and the FSM is in IDLE.

Source files
------------

// File: rtl/locked_adder_response_checker.sv
// rtl/locked_adder_response_checker.sv - golden-sum response checker with windowed error report
// Optional first-failure capture is built when CHECKER_FIRST_FAIL_EN is defined.
`timescale 1ns/1ps
module locked_adder_response_checker #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [CNT_W-1:0]   num_vectors,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [WIDTH:0]     in_result,
    output logic               busy,
    output logic               rpt_valid,
    input  logic               rpt_ready,
    output logic [CNT_W-1:0]   rpt_vectors,
    output logic [CNT_W-1:0]   rpt_err_vectors,
    output logic [CNT_W+7:0]   rpt_err_bits,
    output logic [CNT_W-1:0]   rpt_first_idx,
    output logic [WIDTH-1:0]   rpt_first_a,
    output logic [WIDTH-1:0]   rpt_first_b,
    output logic [WIDTH:0]     rpt_first_result,
    output logic               rpt_first_hit
);

    localparam int RW   = WIDTH + 1;
    localparam int EW   = CNT_W + 8;
    localparam int PC_W = $clog2(WIDTH + 2);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, REPORT} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   target_q, accepted_q;
    logic               drain_q;
    logic               accept;

    logic               s1_valid_q;
    logic [RW-1:0]      s1_golden_q, s1_result_q;
    logic [RW-1:0]      mismatch;
    logic [PC_W-1:0]    popcount;

    logic               s2_valid_q, s2_err_q;
    logic [PC_W-1:0]    s2_bits_q;

    logic [CNT_W-1:0]   vec_q, errv_q;
    logic [EW-1:0]      errb_q, errb_d;
    logic [EW:0]        errb_sum;

    assign in_ready  = (state_q == RUN) && (accepted_q < target_q) && !start;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == RUN) || (state_q == DRAIN);
    assign rpt_valid = (state_q == REPORT);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   state_d = IDLE;
            RUN: begin
                if ((target_q == '0) || (accept && (accepted_q == target_q - CNT_W'(1))))
                    state_d = DRAIN;
            end
            DRAIN:  if (drain_q) state_d = REPORT;
            REPORT: if (rpt_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (start)
            state_d = RUN;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            drain_q    <= 1'b0;
            target_q   <= '0;
            accepted_q <= '0;
        end else begin
            state_q <= state_d;
            // Second DRAIN cycle is the one where the last vector reaches the accumulators.
            drain_q <= (state_q == DRAIN);
            if (start) begin
                target_q   <= num_vectors;
                accepted_q <= '0;
            end else if (accept) begin
                accepted_q <= accepted_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        mismatch = s1_golden_q ^ s1_result_q;
        popcount = '0;
        for (int i = 0; i < RW; i++)
            popcount = popcount + PC_W'(mismatch[i]);
    end

    always_comb begin
        errb_sum = {1'b0, errb_q} + (EW+1)'(s2_bits_q);
        errb_d   = errb_sum[EW] ? {EW{1'b1}} : errb_sum[EW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_golden_q <= '0;
            s1_result_q <= '0;
            s2_valid_q  <= 1'b0;
            s2_err_q    <= 1'b0;
            s2_bits_q   <= '0;
            vec_q       <= '0;
            errv_q      <= '0;
            errb_q      <= '0;
        end else if (start) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            vec_q      <= '0;
            errv_q     <= '0;
            errb_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_golden_q <= {1'b0, in_a} + {1'b0, in_b};
                s1_result_q <= in_result;
            end
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_bits_q <= popcount;
                s2_err_q  <= (mismatch != '0);
            end
            if (s2_valid_q) begin
                vec_q  <= vec_q + CNT_W'(1);
                errv_q <= errv_q + CNT_W'(s2_err_q);
                errb_q <= errb_d;
            end
        end
    end

    assign rpt_vectors     = vec_q;
    assign rpt_err_vectors = errv_q;
    assign rpt_err_bits    = errb_q;

`ifdef CHECKER_FIRST_FAIL_EN
    logic [WIDTH-1:0] s1_a_q, s1_b_q, s2_a_q, s2_b_q, first_a_q, first_b_q;
    logic [RW-1:0]    s2_result_q, first_result_q;
    logic [CNT_W-1:0] first_idx_q;
    logic             first_hit_q;

    // Index of a vector equals the number of vectors accumulated before it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_a_q         <= '0;
            s1_b_q         <= '0;
            s2_a_q         <= '0;
            s2_b_q         <= '0;
            s2_result_q    <= '0;
            first_a_q      <= '0;
            first_b_q      <= '0;
            first_result_q <= '0;
            first_idx_q    <= '0;
            first_hit_q    <= 1'b0;
        end else if (start) begin
            first_a_q      <= '0;
            first_b_q      <= '0;
            first_result_q <= '0;
            first_idx_q    <= '0;
            first_hit_q    <= 1'b0;
        end else begin
            if (accept) begin
                s1_a_q <= in_a;
                s1_b_q <= in_b;
            end
            if (s1_valid_q) begin
                s2_a_q      <= s1_a_q;
                s2_b_q      <= s1_b_q;
                s2_result_q <= s1_result_q;
            end
            if (s2_valid_q && s2_err_q && !first_hit_q) begin
                first_hit_q    <= 1'b1;
                first_idx_q    <= vec_q;
                first_a_q      <= s2_a_q;
                first_b_q      <= s2_b_q;
                first_result_q <= s2_result_q;
            end
        end
    end

    assign rpt_first_idx    = first_idx_q;
    assign rpt_first_a      = first_a_q;
    assign rpt_first_b      = first_b_q;
    assign rpt_first_result = first_result_q;
    assign rpt_first_hit    = first_hit_q;
`else
    assign rpt_first_idx    = '0;
    assign rpt_first_a      = '0;
    assign rpt_first_b      = '0;
    assign rpt_first_result = '0;
    assign rpt_first_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_locked_adder_response_checker.sv
// tb/tb_locked_adder_response_checker.sv - scoreboard bench for locked_adder_response_checker
`timescale 1ns/1ps
module tb_locked_adder_response_checker;

    logic        clk = 1'b0;
    logic        rst, start, in_valid, rpt_ready;
    logic [15:0] num_vectors, in_a, in_b;
    logic [16:0] in_result;
    logic        in_ready, busy, rpt_valid, rpt_first_hit;
    logic [15:0] rpt_vectors, rpt_err_vectors, rpt_first_idx, rpt_first_a, rpt_first_b;
    logic [23:0] rpt_err_bits;
    logic [16:0] rpt_first_result;

`ifdef CHECKER_FIRST_FAIL_EN
    localparam bit FF_EN = 1'b1;
`else
    localparam bit FF_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    locked_adder_response_checker #(.WIDTH(16), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .num_vectors(num_vectors),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
        .in_result(in_result), .busy(busy), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_vectors(rpt_vectors), .rpt_err_vectors(rpt_err_vectors), .rpt_err_bits(rpt_err_bits),
        .rpt_first_idx(rpt_first_idx), .rpt_first_a(rpt_first_a), .rpt_first_b(rpt_first_b),
        .rpt_first_result(rpt_first_result), .rpt_first_hit(rpt_first_hit)
    );

    typedef struct {
        logic [15:0] vec, errv, idx, fa, fb;
        logic [23:0] errb;
        logic        hit;
        logic [16:0] fr;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] v, input logic [15:0] ev, input logic [23:0] eb,
                                input logic h, input logic [15:0] idx, input logic [15:0] fa,
                                input logic [15:0] fb, input logic [16:0] fr);
        exp_t e;
        e.vec  = v;
        e.errv = ev;
        e.errb = eb;
        e.hit  = h & FF_EN;
        e.idx  = FF_EN ? idx : 16'h0;
        e.fa   = FF_EN ? fa  : 16'h0;
        e.fb   = FF_EN ? fb  : 16'h0;
        e.fr   = FF_EN ? fr  : 17'h0;
        return e;
    endfunction

    // Monitor: compare each report at the cycle its handshake is presented.
    always @(negedge clk) begin
        #2;
        if (!rst && rpt_valid && rpt_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_report", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("rpt_vectors",      rpt_vectors,      mon_e.vec);
                chk("rpt_err_vectors",  rpt_err_vectors,  mon_e.errv);
                chk("rpt_err_bits",     rpt_err_bits,     mon_e.errb);
                chk("rpt_first_hit",    rpt_first_hit,    mon_e.hit);
                chk("rpt_first_idx",    rpt_first_idx,    mon_e.idx);
                chk("rpt_first_a",      rpt_first_a,      mon_e.fa);
                chk("rpt_first_b",      rpt_first_b,      mon_e.fb);
                chk("rpt_first_result", rpt_first_result, mon_e.fr);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic do_start(input logic [15:0] n);
        @(negedge clk);
        start = 1'b1;
        num_vectors = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_vec(input logic [15:0] a, input logic [15:0] b, input logic [16:0] r);
        int k = 0;
        @(negedge clk);
        in_valid = 1'b1; in_a = a; in_b = b; in_result = r;
        #1;
        while (!in_ready && k < 20) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1'b1);
        @(posedge clk);
    endtask

    task automatic check_latency(input string name);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        chk({name, "_ready_low"}, in_ready, 1'b0);
        chk({name, "_valid_n1"}, rpt_valid, 1'b0);
        @(negedge clk);
        #1;
        chk({name, "_valid_n2"}, rpt_valid, 1'b0);
        @(negedge clk);
        #1;
        chk({name, "_valid_rise"}, rpt_valid, 1'b1);
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while ((rpt_valid || busy) && k < 50) begin
            @(negedge clk);
            #1;
            k++;
        end
        chk({name, "_done"}, rpt_valid | busy, 1'b0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; num_vectors = '0; in_valid = 1'b0;
        in_a = '0; in_b = '0; in_result = '0; rpt_ready = 1'b1;
        #1;
        chk("reset_rpt_valid", rpt_valid, 1'b0);
        chk("reset_busy", busy, 1'b0);
        chk("reset_in_ready", in_ready, 1'b0);
        chk("reset_vectors", rpt_vectors, 16'h0);
        chk("reset_err_bits", rpt_err_bits, 24'h0);
        chk("reset_first_hit", rpt_first_hit, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Match case
        exp_q.push_back(mk(16'd3, 16'd0, 24'd0, 1'b0, 16'd0, 16'h0, 16'h0, 17'h0));
        do_start(16'd3);
        send_vec(16'h0001, 16'h0001, 17'h00002);
        send_vec(16'hFFFF, 16'h0001, 17'h10000);
        send_vec(16'h1234, 16'h4321, 17'h05555);
        check_latency("match");
        wait_done("match");

        // Corruption: 1 bit + 9 bits
        exp_q.push_back(mk(16'd2, 16'd2, 24'd10, 1'b1, 16'd0, 16'h0001, 16'h0001, 17'h00003));
        do_start(16'd2);
        send_vec(16'h0001, 16'h0001, 17'h00003);
        send_vec(16'h00FF, 16'h0001, 17'h000FF);
        check_latency("corrupt");
        wait_done("corrupt");

        // Backpressure
        rpt_ready = 1'b0;
        exp_q.push_back(mk(16'd1, 16'd1, 24'd1, 1'b1, 16'd0, 16'h8000, 16'h8000, 17'h00000));
        do_start(16'd1);
        send_vec(16'h8000, 16'h8000, 17'h00000);
        check_latency("bp");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_valid_held", rpt_valid, 1'b1);
            chk("bp_err_bits_stable", rpt_err_bits, 24'd1);
            chk("bp_in_ready", in_ready, 1'b0);
            chk("bp_busy", busy, 1'b0);
        end
        @(negedge clk);
        rpt_ready = 1'b1;
        @(negedge clk);
        #1;
        chk("bp_valid_drop", rpt_valid, 1'b0);
        chk("bp_fields_kept", rpt_err_bits, 24'd1);

        // Restart mid-run with a coincident vector
        exp_q.push_back(mk(16'd1, 16'd0, 24'd0, 1'b0, 16'd0, 16'h0, 16'h0, 17'h0));
        do_start(16'd4);
        send_vec(16'h0001, 16'h0001, 17'h00000);
        send_vec(16'h0002, 16'h0002, 17'h00000);
        @(negedge clk);
        start = 1'b1; num_vectors = 16'd1;
        in_valid = 1'b1; in_a = 16'h0000; in_b = 16'h0000; in_result = 17'h00001;
        #1;
        chk("restart_in_ready_blocked", in_ready, 1'b0);
        @(negedge clk);
        start = 1'b0; in_valid = 1'b0;
        #1;
        chk("restart_busy", busy, 1'b1);
        chk("restart_cleared", rpt_err_vectors, 16'd0);
        send_vec(16'h0003, 16'h0004, 17'h00007);
        check_latency("restart");
        wait_done("restart");

        // Zero-length window
        exp_q.push_back(mk(16'd0, 16'd0, 24'd0, 1'b0, 16'd0, 16'h0, 16'h0, 17'h0));
        begin
            int k = 0;
            @(negedge clk);
            start = 1'b1; num_vectors = 16'd0;
            @(negedge clk);
            start = 1'b0;
            #1;
            while (!rpt_valid && k < 3) begin
                @(negedge clk);
                #1;
                k++;
            end
            chk("zero_latency", rpt_valid, 1'b1);
        end
        wait_done("zero");

        // Async reset with a vector still in the pipeline
        do_start(16'd4);
        send_vec(16'h0001, 16'h0001, 17'h00003);
        send_vec(16'h0002, 16'h0002, 17'h00004);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #3;
        chk("ar_pre_err_bits", rpt_err_bits, 24'd1);
        chk("ar_pre_busy", busy, 1'b1);
        rst = 1'b1;
        #1;
        chk("ar_in_ready", in_ready, 1'b0);
        chk("ar_busy", busy, 1'b0);
        chk("ar_rpt_valid", rpt_valid, 1'b0);
        chk("ar_vectors", rpt_vectors, 16'd0);
        chk("ar_err_vectors", rpt_err_vectors, 16'd0);
        chk("ar_err_bits", rpt_err_bits, 24'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        chk("ar_idle_busy", busy, 1'b0);
        chk("ar_idle_valid", rpt_valid, 1'b0);

        repeat (2) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
